// File: rtl/filt_pkg.sv
// Constants and types shared across the filter word-routing blocks (4:1 mux, 1:4 demux).
package filt_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned DATA_W = 32;

    typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/demux_slot.sv
// One-entry output holding register with valid flag for a single demux channel.
module demux_slot #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         out_ready,
    output logic         v,
    output logic [W-1:0] d
);

    // A load wins over a drain, so a same-cycle load and drain replaces the word and keeps v set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v <= 1'b0;
            d <= '0;
        end else if (load) begin
            v <= 1'b1;
            d <= load_data;
        end else if (out_ready) begin
            v <= 1'b0;
        end
    end

endmodule

// File: rtl/demux1_4_reg.sv
// Registered 1-to-4 word distributor: steers each accepted input word to the channel picked by s.
module demux1_4_reg
    import filt_pkg::*;
#(
    parameter int unsigned W = DATA_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SEL_W-1:0]    s,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        in_data,
    output logic [W-1:0]        y0,
    output logic [W-1:0]        y1,
    output logic [W-1:0]        y2,
    output logic [W-1:0]        y3,
    output logic [NUM_CH-1:0]   out_valid,
    input  logic [NUM_CH-1:0]   out_ready,
    output logic                busy
);

    sel_t              sel;
    logic [NUM_CH-1:0] load;
    logic [NUM_CH-1:0] v_q;
    logic [W-1:0]      d_q [NUM_CH];

    assign sel = s;

    // Selected slot can take a word if empty or being drained this cycle.
    always_comb begin
        in_ready = rst_n && (!v_q[sel] || out_ready[sel]);
    end

    // Select is only decoded on a valid beat so an undriven s never reaches the slots.
    always_comb begin
        load = '0;
        if (in_valid && in_ready) begin
            load[sel] = 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        demux_slot #(
            .W(W)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[k]),
            .load_data (in_data),
            .out_ready (out_ready[k]),
            .v         (v_q[k]),
            .d         (d_q[k])
        );
    end

    assign out_valid = v_q;
    assign busy      = |v_q;
    assign y0        = d_q[0];
    assign y1        = d_q[1];
    assign y2        = d_q[2];
    assign y3        = d_q[3];

endmodule

// File: tb/tb_demux1_4_reg.sv
// Scoreboard bench for demux1_4_reg: per-channel expected-word queues drained by a negedge monitor.
module tb_demux1_4_reg;

    logic        clk;
    logic        rst_n;
    logic [1:0]  s;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [31:0] y0, y1, y2, y3;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic        busy;

    logic [31:0] yv [4];
    logic [31:0] exp_q [4][$];
    int          n_cmp;
    int          n_err;
    bit          done;

    demux1_4_reg #(.W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s         (s),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .y0        (y0),
        .y1        (y1),
        .y2        (y2),
        .y3        (y3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    assign yv[0] = y0;
    assign yv[1] = y1;
    assign yv[2] = y2;
    assign yv[3] = y3;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one beat from posedge+1; check in_ready at negedge and record the word if it is taken.
    task automatic send(input logic [1:0] ch, input logic [31:0] dat, input logic exp_rdy);
        in_valid = 1'b1;
        s        = ch;
        in_data  = dat;
        @(negedge clk);
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        if (in_ready) exp_q[ch].push_back(dat);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        done      = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        s         = 2'd0;
        in_data   = '0;
        out_ready = 4'hf;

        fork
            begin : monitor
                while (!done) begin
                    @(negedge clk);
                    for (int k = 0; k < 4; k++) begin
                        if (rst_n && out_valid[k] && out_ready[k]) begin
                            n_cmp++;
                            if (exp_q[k].size() == 0) begin
                                n_err++;
                                $display("FAIL deliver_ch%0d: got %h expected no word at %0t", k, yv[k], $time);
                            end else begin
                                chk($sformatf("y%0d", k), yv[k], exp_q[k].pop_front());
                            end
                        end
                    end
                end
            end
            begin : stimulus
                // 1: reset and route
                repeat (3) @(posedge clk);
                @(negedge clk);
                chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
                chk("rst_out_valid", {28'd0, out_valid}, 32'd0);
                repeat (2) @(posedge clk);
                #1;
                rst_n = 1'b1;
                @(negedge clk);
                chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
                chk("rel_busy", {31'd0, busy}, 32'd0);
                chk("rel_y0", y0, 32'd0);
                chk("rel_y3", y3, 32'd0);
                @(posedge clk);
                #1;
                for (int i = 0; i < 4; i++) send(2'(i), 32'(i), 1'b1);
                idle(3);

                // 2: stall channel 2
                out_ready = 4'b1011;
                send(2'd2, 32'hA5A5A5A5, 1'b1);
                @(negedge clk);
                chk("stall_y2", y2, 32'hA5A5A5A5);
                chk("stall_v2", {31'd0, out_valid[2]}, 32'd1);
                @(posedge clk);
                #1;
                in_valid = 1'b1;
                s        = 2'd2;
                in_data  = 32'hDEADBEEF;
                repeat (2) begin
                    @(negedge clk);
                    chk("blocked_in_ready", {31'd0, in_ready}, 32'd0);
                    @(posedge clk);
                    #1;
                end
                in_valid = 1'b0;

                // 3: independence while channel 2 is stalled
                send(2'd1, 32'd7, 1'b1);
                @(negedge clk);
                chk("indep_y2", y2, 32'hA5A5A5A5);
                chk("indep_v2", {31'd0, out_valid[2]}, 32'd1);
                @(posedge clk);
                #1;
                out_ready = 4'hf;
                send(2'd2, 32'hDEADBEEF, 1'b1);
                idle(2);

                // 4: full-rate pass-through on channel 3
                for (int i = 0; i < 16; i++) send(2'd3, 32'h10 + 32'(i), 1'b1);
                idle(2);

                // 5: select flip while blocked
                out_ready = 4'b1110;
                send(2'd0, 32'h55, 1'b1);
                in_valid = 1'b1;
                s        = 2'd0;
                in_data  = 32'h77;
                @(negedge clk);
                chk("flip_blocked", {31'd0, in_ready}, 32'd0);
                s = 2'd3;
                #1;
                chk("flip_ready", {31'd0, in_ready}, 32'd1);
                if (in_ready) exp_q[3].push_back(32'h77);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                @(negedge clk);
                chk("flip_y0", y0, 32'h55);
                chk("flip_v0", {31'd0, out_valid[0]}, 32'd1);
                @(posedge clk);
                #1;
                out_ready = 4'hf;
                idle(2);

                // 6: reset mid-operation discards all held words
                out_ready = 4'h0;
                for (int i = 0; i < 4; i++) send(2'(i), 32'(i), 1'b1);
                @(negedge clk);
                chk("full_out_valid", {28'd0, out_valid}, 32'hf);
                chk("full_busy", {31'd0, busy}, 32'd1);
                @(posedge clk);
                #1;
                rst_n = 1'b0;
                @(negedge clk);
                chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
                @(posedge clk);
                #1;
                for (int k = 0; k < 4; k++) exp_q[k].delete();
                rst_n     = 1'b1;
                out_ready = 4'hf;
                @(negedge clk);
                chk("midrst_out_valid", {28'd0, out_valid}, 32'd0);
                chk("midrst_busy", {31'd0, busy}, 32'd0);
                chk("midrst_y0", y0, 32'd0);
                chk("midrst_y1", y1, 32'd0);
                chk("midrst_y2", y2, 32'd0);
                chk("midrst_y3", y3, 32'd0);
                @(posedge clk);
                #1;
                idle(4);

                for (int k = 0; k < 4; k++) begin
                    chk($sformatf("leftover_ch%0d", k), 32'(exp_q[k].size()), 32'd0);
                end
                done = 1'b1;
            end
        join

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
